instr_fetch_unit: RTL and testbench

//  Upstream fetch stage of the multi-cycle RV core. It owns the PC and the instruction register (IR),
//  and runs one instruction-memory read per fetch request from the microcoded control unit.
//  It presents the latched opcode and register fields to the opcode decoder and control store.
//  It signals completion, or a fetch fault, back to the control unit.

---
 rtl/rvs_pkg.sv | 30 +++
 rtl/ir_split.sv | 21 ++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvs_pkg.sv
// Shared types and constants for the fetch stage and the opcode decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUS      = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_t;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_JALR  = 7'h67;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/ir_split.sv
// Slices an instruction word into its RV32 register/opcode fields.
// Latency: purely combinational.
// Backpressure: none.
module ir_split (
    input  logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3
);

    always_comb begin
        opcode = ir[6:0];
        rd     = ir[11:7];
        funct3 = ir[14:12];
        rs1    = ir[19:15];
        rs2    = ir[24:20];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs one imem read per fetch_req, reports done or sticky fault.
// Latency: fetch_req to fetch_done is 3 cycles with a zero-wait ack, +1 per wait cycle.
// Backpressure: imem_req held with stable address until imem_ack or MAX_WAIT timeout.
module instr_fetch_unit
    import rvs_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_req,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_err,
    output logic            fetch_done,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t    state;
    fault_cause_t    cause;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_ir;
    logic [31:0]     ir_q;
    logic            pend_vld;
    logic [XLEN-1:0] pend_tgt;
    logic [7:0]      wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cause    <= CAUSE_NONE;
            pc       <= RESET_PC;
            pc_ir    <= RESET_PC;
            ir_q     <= NOP_INSN;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_load) begin
                        pc <= pc_target;
                    end
                    // Alignment is judged on the PC as it stands this cycle.
                    if (fetch_req) begin
                        if (pc[1:0] != 2'b00) begin
                            state <= ST_FAULT;
                            cause <= CAUSE_MISALIGN;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                    if (pc_load) begin
                        pend_vld <= 1'b1;
                        pend_tgt <= pc_target;
                    end
                end
                ST_WAIT: begin
                    if (pc_load) begin
                        pend_vld <= 1'b1;
                        pend_tgt <= pc_target;
                    end
                    // An ack arriving on the timeout cycle still completes the fetch.
                    if (imem_ack) begin
                        if (imem_err) begin
                            state <= ST_FAULT;
                            cause <= CAUSE_BUS;
                        end else begin
                            ir_q  <= imem_rdata;
                            pc_ir <= pc;
                            pc    <= pc + XLEN'(4);
                            state <= ST_DONE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ST_FAULT;
                        cause <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    pend_vld <= 1'b0;
                    if (pc_load) begin
                        pc <= pc_target;
                    end else if (pend_vld) begin
                        pc <= pend_tgt;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req    = (state == ST_REQ) || (state == ST_WAIT);
        imem_addr   = pc;
        fetch_done  = (state == ST_DONE);
        fault       = (state == ST_FAULT);
        fault_cause = cause;
        ir          = ir_q;
        pc_out      = pc_ir;
        pc_plus4    = pc_ir + XLEN'(4);
    end

    ir_split u_ir_split (
        .ir     (ir_q),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch timing, wait/jump, faults, wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        fetch_done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .fetch_done  (fetch_done),
        .fault       (fault),
        .fault_cause (fault_cause),
        .ir          (ir),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct3      (funct3),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        pc_load    = 1'b0;
        pc_target  = '0;
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_pcout", pc_out, 32'h100);
        chk("rst_addr",  imem_addr, 32'h100);
        chk("rst_ir",    ir, 32'h0000_0013);
        chk("rst_done",  32'(fetch_done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);

        // Zero-wait fetch: done on the third edge after fetch_req
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("zw_req_c1",  32'(imem_req), 32'd1);
        chk("zw_addr_c1", imem_addr, 32'h100);
        step();
        chk("zw_req_c2",  32'(imem_req), 32'd1);
        chk("zw_done_c2", 32'(fetch_done), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A2_8293;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("zw_done",   32'(fetch_done), 32'd1);
        chk("zw_ir",     ir, 32'h00A2_8293);
        chk("zw_opcode", 32'(opcode), 32'h13);
        chk("zw_rd",     32'(rd), 32'd5);
        chk("zw_rs1",    32'(rs1), 32'd5);
        chk("zw_rs2",    32'(rs2), 32'd10);
        chk("zw_funct3", 32'(funct3), 32'd0);
        chk("zw_pcout",  pc_out, 32'h100);
        chk("zw_pc4",    pc_plus4, 32'h104);
        chk("zw_pc",     imem_addr, 32'h104);
        step();
        chk("zw_done_pulse", 32'(fetch_done), 32'd0);
        chk("zw_req_idle",   32'(imem_req), 32'd0);

        // Three wait cycles, jump requested during the second one
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("ws_addr_req", imem_addr, 32'h100);
        step();
        chk("ws_addr_w1", imem_addr, 32'h100);
        step();
        chk("ws_addr_w2", imem_addr, 32'h100);
        pc_load   = 1'b1;
        pc_target = 32'h200;
        step();
        pc_load   = 1'b0;
        pc_target = '0;
        chk("ws_addr_w3", imem_addr, 32'h100);
        chk("ws_req_w3",  32'(imem_req), 32'd1);
        step();
        // Fourth WAIT cycle is also the timeout cycle: the ack must win
        chk("ws_addr_w4",  imem_addr, 32'h100);
        chk("ws_fault_w4", 32'(fault), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0033;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("ws_done",  32'(fetch_done), 32'd1);
        chk("ws_fault", 32'(fault), 32'd0);
        chk("ws_ir",    ir, 32'h0000_0033);
        chk("ws_pcout", pc_out, 32'h100);
        step();
        chk("ws_jump_pc", imem_addr, 32'h200);

        // Stray ack in IDLE must not touch IR
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("stray_ir",   ir, 32'h0000_0033);
        chk("stray_done", 32'(fetch_done), 32'd0);

        // Bus error from PC 0x200
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("be_addr", imem_addr, 32'h200);
        step();
        imem_ack   = 1'b1;
        imem_err   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = '0;
        chk("be_fault", 32'(fault), 32'd1);
        chk("be_cause", 32'(fault_cause), 32'd2);
        chk("be_ir",    ir, 32'h0000_0033);
        chk("be_req",   32'(imem_req), 32'd0);
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_target = 32'h300;
        step();
        step();
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        chk("be_sticky_req",   32'(imem_req), 32'd0);
        chk("be_sticky_fault", 32'(fault), 32'd1);
        chk("be_load_ignored", imem_addr, 32'h200);

        // Timeout after four unacknowledged WAIT cycles
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        repeat (4) step();
        chk("to_req_w4",   32'(imem_req), 32'd1);
        chk("to_fault_w4", 32'(fault), 32'd0);
        step();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd3);
        chk("to_req",   32'(imem_req), 32'd0);

        // Misaligned PC
        do_reset();
        pc_load   = 1'b1;
        pc_target = 32'h102;
        step();
        pc_load   = 1'b0;
        chk("ma_addr", imem_addr, 32'h102);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("ma_req",   32'(imem_req), 32'd0);
        chk("ma_fault", 32'(fault), 32'd1);
        chk("ma_cause", 32'(fault_cause), 32'd1);

        // Reset mid-fetch clears outputs at once; a late ack is ignored
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_req_async", 32'(imem_req), 32'd0);
        step();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("mr_late_ir",   ir, 32'h0000_0013);
        chk("mr_late_done", 32'(fetch_done), 32'd0);

        // PC wrap at the top of the address space
        do_reset();
        pc_load   = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        step();
        pc_load   = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0041_2083;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("wr_done",   32'(fetch_done), 32'd1);
        chk("wr_pcout",  pc_out, 32'hFFFF_FFFC);
        chk("wr_pc4",    pc_plus4, 32'h0);
        chk("wr_pc",     imem_addr, 32'h0);
        chk("wr_opcode", 32'(opcode), 32'h03);
        chk("wr_rd",     32'(rd), 32'd1);
        chk("wr_rs1",    32'(rs1), 32'd2);
        chk("wr_funct3", 32'(funct3), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
